// File: rtl/alu_requester.sv
// rtl/alu_requester.sv - command FIFO feeding an arithmetic FSM with timeout and registered response
//
// Purpose: queues add/subtract commands. It issues them one at a time to an
// external arithmetic FSM using a ready/valid request. If the FSM does not answer
// within TIMEOUT cycles, the block returns an error response. Responses are held
// in a single output register until the consumer accepts them.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_add_sub, cmd_a, cmd_b payload
//   alu_ready                   request to arithmetic FSM (high only while issuing)
//   alu_add_sub, alu_a, alu_b   operands held stable while alu_ready is high
//   alu_valid, alu_res          result from arithmetic FSM (ignored unless issuing)
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_err payload
//   count                       command FIFO occupancy
module alu_requester #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_add_sub,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    output logic                     alu_ready,
    output logic                     alu_add_sub,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_res,
    input  logic                     alu_valid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2*WIDTH:0]    mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [TW-1:0]       timer;
    logic [WIDTH-1:0]    res_q;
    logic                err_q;
    logic                push;
    logic                pop;
    logic                timed_out;
    logic                rsp_load;

    // The full flag comes straight from count: a command offered while full
    // waits, even if a pop happens on the same edge.
    assign cmd_ready = (count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    // The output register can take a new result when it is empty or is being drained this cycle.
    assign rsp_load  = (state == DONE) && (!rsp_valid || rsp_ready);
    assign alu_ready = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = ISSUE;
            ISSUE:   if (alu_valid || timed_out) state_nxt = DONE;
            DONE:    if (rsp_load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage needs no reset; only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_add_sub, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue registers and result capture. alu_valid wins over the timeout on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_add_sub <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            timer       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
        end else if (pop) begin
            {alu_add_sub, alu_a, alu_b} <= mem[rd_ptr];
            timer                       <= '0;
        end else if (state == ISSUE) begin
            if (alu_valid) begin
                res_q <= alu_res;
                err_q <= 1'b0;
            end else if (timed_out) begin
                res_q <= '0;
                err_q <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= res_q;
            rsp_err   <= err_q;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_requester.sv
// tb/tb_alu_requester.sv - directed self-checking bench for alu_requester
module tb_alu_requester;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_add_sub = 1'b0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         alu_ready;
    logic         alu_add_sub;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res = 4'hA;
    logic         alu_valid = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic [2:0]   count;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 2;
    int cyc = 0;
    logic [4:0] rsp_q[$];

    alu_requester dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_add_sub(cmd_add_sub),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_ready(alu_ready), .alu_add_sub(alu_add_sub), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_valid(alu_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .count(count)
    );

    always #5 clk = ~clk;

    // Arithmetic FSM model: answers 'lat' cycles after alu_ready rises; lat == 0 never answers.
    always @(posedge clk) begin
        #1;
        if (alu_ready) begin
            cyc = cyc + 1;
            if (lat != 0 && cyc == lat) begin
                alu_valid = 1'b1;
                alu_res   = alu_add_sub ? W'(alu_a + alu_b) : W'(alu_a - alu_b);
            end else begin
                alu_valid = 1'b0;
                alu_res   = 4'hA;
            end
        end else begin
            cyc       = 0;
            alu_valid = 1'b0;
            alu_res   = 4'hA;
        end
    end

    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            step();
            t++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL push_wait: cmd_ready got %b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_add_sub = op; cmd_a = a; cmd_b = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_q.size() < n && t < 100) begin
            step();
            t++;
        end
        repeat (5) step();
        n_cmp++;
        if (rsp_q.size() != n) begin
            n_bad++;
            $display("FAIL rsp_count: got %0d required %0d", rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({cmd_ready, alu_ready, count, rsp_valid} !== 6'b1_0_000_0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 100000", {cmd_ready, alu_ready, count, rsp_valid});
        end
        n_cmp++;
        if ({rsp_data, rsp_err} !== 5'h00) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h required 00", {rsp_data, rsp_err});
        end
        n_cmp++;
        if ({alu_add_sub, alu_a, alu_b} !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_alu: got %h required 000", {alu_add_sub, alu_a, alu_b});
        end
        reset = 1'b1;
    endtask

    task automatic test_add();
        rsp_q.delete(); lat = 2; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_add_sub = 1'b1; cmd_a = 4'd3; cmd_b = 4'd5;
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({count, alu_ready} !== 4'b001_0) begin
            n_bad++;
            $display("FAIL first_push: got %b required 0010", {count, alu_ready});
        end
        step();
        n_cmp++;
        if ({alu_ready, alu_add_sub, alu_a, alu_b, count} !== {1'b1, 1'b1, 4'd3, 4'd5, 3'd0}) begin
            n_bad++;
            $display("FAIL issue_regs: got %h required %h", {alu_ready, alu_add_sub, alu_a, alu_b, count},
                     {1'b1, 1'b1, 4'd3, 4'd5, 3'd0});
        end
        step(); step();
        n_cmp++;
        if ({rsp_valid, alu_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL latency_early: got %b required 00", {rsp_valid, alu_ready});
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 4'd8}) begin
            n_bad++;
            $display("FAIL add_rsp: got %h required %h", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 4'd8});
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rsp_clear: got %b required 0", rsp_valid);
        end
        wait_rsp(1);
    endtask

    task automatic test_back_to_back();
        rsp_q.delete(); lat = 2; rsp_ready = 1'b1;
        push_cmd(1'b0, 4'd0, 4'd1);
        push_cmd(1'b1, 4'd15, 4'd1);
        wait_rsp(2);
        if (rsp_q.size() == 2) begin
            n_cmp++;
            if (rsp_q[0] !== {1'b0, 4'd15}) begin
                n_bad++;
                $display("FAIL b2b_first: got %h required %h", rsp_q[0], {1'b0, 4'd15});
            end
            n_cmp++;
            if (rsp_q[1] !== {1'b0, 4'd0}) begin
                n_bad++;
                $display("FAIL b2b_second: got %h required %h", rsp_q[1], {1'b0, 4'd0});
            end
        end
    endtask

    task automatic test_timeout();
        int t = 0;
        int n = 0;
        rsp_q.delete(); lat = 0; rsp_ready = 1'b1;
        push_cmd(1'b1, 4'd7, 4'd7);
        push_cmd(1'b1, 4'd2, 4'd2);
        while (!alu_ready && t < 20) begin
            step();
            t++;
        end
        while (alu_ready && n < 30) begin
            n++;
            step();
        end
        lat = 1;
        n_cmp++;
        if (n != 8) begin
            n_bad++;
            $display("FAIL issue_cycles: got %0d required 8", n);
        end
        wait_rsp(2);
        if (rsp_q.size() == 2) begin
            n_cmp++;
            if (rsp_q[0] !== {1'b1, 4'd0}) begin
                n_bad++;
                $display("FAIL timeout_rsp: got %h required %h", rsp_q[0], {1'b1, 4'd0});
            end
            n_cmp++;
            if (rsp_q[1] !== {1'b0, 4'd4}) begin
                n_bad++;
                $display("FAIL after_timeout: got %h required %h", rsp_q[1], {1'b0, 4'd4});
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int t = 0;
        logic acc;
        rsp_q.delete(); lat = 1; rsp_ready = 1'b0;
        while (sent < 6 && t < 80) begin
            cmd_valid = 1'b1; cmd_add_sub = 1'b1; cmd_a = 4'(sent); cmd_b = 4'(sent + 1);
            acc = cmd_ready;
            step();
            if (acc) sent++;
            t++;
        end
        cmd_valid = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (sent != 6) begin
            n_bad++;
            $display("FAIL bp_accepted: got %0d required 6", sent);
        end
        n_cmp++;
        if ({count, cmd_ready, alu_ready} !== 5'b100_0_0) begin
            n_bad++;
            $display("FAIL bp_full: got %b required 10000", {count, cmd_ready, alu_ready});
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 4'd1}) begin
            n_bad++;
            $display("FAIL bp_hold: got %h required %h", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 4'd1});
        end
        rsp_ready = 1'b1;
        wait_rsp(6);
        if (rsp_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (rsp_q[i] !== {1'b0, 4'(2 * i + 1)}) begin
                    n_bad++;
                    $display("FAIL bp_rsp%0d: got %h required %h", i, rsp_q[i], {1'b0, 4'(2 * i + 1)});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_q.delete(); lat = 0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 4'(i), 4'd1);
        n_cmp++;
        if ({alu_ready, count} !== 4'b1_011) begin
            n_bad++;
            $display("FAIL pre_reset: got %b required 1011", {alu_ready, count});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({alu_ready, count, rsp_valid, cmd_ready} !== 6'b0_000_0_1) begin
            n_bad++;
            $display("FAIL async_reset: got %b required 000001", {alu_ready, count, rsp_valid, cmd_ready});
        end
        step(); step();
        reset = 1'b1;
        lat = 1;
        repeat (25) step();
        n_cmp++;
        if (rsp_q.size() != 0 || {alu_ready, count} !== 4'b0) begin
            n_bad++;
            $display("FAIL post_reset: got %0d rsp, %b required 0 rsp, 0000", rsp_q.size(), {alu_ready, count});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
